// File: rtl/logic_result_buffer.sv
// Two-entry result FIFO for the logic unit. It stores each result together with
// its opcode and flags (zero, msb, parity), which are computed when the entry is pushed.
module logic_result_buffer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_op,
  output logic             out_zero,
  output logic             out_msb,
  output logic             out_parity,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] acc_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [1:0]       op;
    logic             zero;
    logic             msb;
    logic             parity;
  } entry_t;

  entry_t           mem_q [2];
  entry_t           mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       level_q, level_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             rdy_q, rdy_d;
  logic             push;
  logic             pop;
  entry_t           new_entry;
  entry_t           head;

  // in_ready comes from a flop that mirrors (level != 2). This keeps it low
  // during reset and means out_ready has no combinational path to it.
  assign in_ready  = rdy_q;
  assign out_valid = (level_q != 2'd0);
  assign push      = in_valid & rdy_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    new_entry        = '0;
    new_entry.result = in_result;
    new_entry.op     = in_op;
    new_entry.zero   = (in_result == '0);
    new_entry.msb    = in_result[WIDTH-1];
    new_entry.parity = ^in_result;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    acc_d    = acc_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = ~wr_ptr_q;
      acc_d           = acc_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase
    rdy_d = (level_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= '0;
      acc_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      acc_q    <= acc_d;
      rdy_q    <= rdy_d;
    end
  end

  // Storage is not reset. Its contents are masked at the outputs while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_result = '0;
    out_op     = '0;
    out_zero   = 1'b0;
    out_msb    = 1'b0;
    out_parity = 1'b0;
    if (out_valid) begin
      out_result = head.result;
      out_op     = head.op;
      out_zero   = head.zero;
      out_msb    = head.msb;
      out_parity = head.parity;
    end
  end

  assign level     = level_q;
  assign acc_count = acc_q;

endmodule

// File: tb/tb_logic_result_buffer.sv
// Directed, table-driven bench for logic_result_buffer. It also covers counter wrap and reset in the middle of a stream.
module tb_logic_result_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [1:0] out_op;
  logic       out_zero;
  logic       out_msb;
  logic       out_parity;
  logic [1:0] level;
  logic [7:0] acc_count;

  int total = 0;
  int bad   = 0;

  logic_result_buffer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_zero   (out_zero),
    .out_msb    (out_msb),
    .out_parity (out_parity),
    .level      (level),
    .acc_count  (acc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] res;
    logic [1:0] op;
    logic       ordy;
    logic       e_ov;
    logic [1:0] e_lvl;
    logic       e_irdy;
    logic [3:0] e_res;
    logic [1:0] e_op;
    logic       e_z;
    logic       e_m;
    logic       e_p;
    logic [7:0] e_acc;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, ".out_valid"},  32'(out_valid),  32'(v.e_ov));
    chk({p, ".level"},      32'(level),      32'(v.e_lvl));
    chk({p, ".in_ready"},   32'(in_ready),   32'(v.e_irdy));
    chk({p, ".out_result"}, 32'(out_result), 32'(v.e_res));
    chk({p, ".out_op"},     32'(out_op),     32'(v.e_op));
    chk({p, ".out_zero"},   32'(out_zero),   32'(v.e_z));
    chk({p, ".out_msb"},    32'(out_msb),    32'(v.e_m));
    chk({p, ".out_parity"}, 32'(out_parity), 32'(v.e_p));
    chk({p, ".acc_count"},  32'(acc_count),  32'(v.e_acc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.level",     32'(level),     32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.acc",       32'(acc_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_op     = '0;
    out_ready = 1'b0;

    // iv res op ordy | ov lvl irdy res op z m p acc  (expected after the edge)
    vecs[0]  = '{1'b0, 4'hF, 2'd3, 1'b1, 1'b0, 2'd0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 4'hA, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 4'h5, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 4'h7, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 4'h8, 2'd3, 1'b1, 1'b0, 2'd0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 4'h0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{1'b0, 4'h3, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 4'hB, 2'd2, 1'b0, 1'b1, 2'd1, 1'b1, 4'hB, 2'd2, 1'b0, 1'b1, 1'b1, 8'd2};
    vecs[8]  = '{1'b1, 4'h8, 2'd3, 1'b0, 1'b1, 2'd2, 1'b0, 4'hB, 2'd2, 1'b0, 1'b1, 1'b1, 8'd3};
    vecs[9]  = '{1'b1, 4'h1, 2'd1, 1'b0, 1'b1, 2'd2, 1'b0, 4'hB, 2'd2, 1'b0, 1'b1, 1'b1, 8'd3};
    vecs[10] = '{1'b1, 4'h1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 4'h8, 2'd3, 1'b0, 1'b1, 1'b1, 8'd3};
    vecs[11] = '{1'b1, 4'h6, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 4'h6, 2'd1, 1'b0, 1'b0, 1'b0, 8'd4};
    vecs[12] = '{1'b0, 4'h9, 2'd2, 1'b0, 1'b1, 2'd1, 1'b1, 4'h6, 2'd1, 1'b0, 1'b0, 1'b0, 8'd4};
    vecs[13] = '{1'b1, 4'hF, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 4'h6, 2'd1, 1'b0, 1'b0, 1'b0, 8'd5};
    vecs[14] = '{1'b0, 4'h2, 2'd3, 1'b0, 1'b1, 2'd2, 1'b0, 4'h6, 2'd1, 1'b0, 1'b0, 1'b0, 8'd5};
    vecs[15] = '{1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b1, 4'hF, 2'd0, 1'b0, 1'b1, 1'b0, 8'd5};
    vecs[16] = '{1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd5};
    vecs[17] = '{1'b0, 4'hC, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd5};
    vecs[18] = '{1'b1, 4'h7, 2'd2, 1'b1, 1'b1, 2'd1, 1'b1, 4'h7, 2'd2, 1'b0, 1'b0, 1'b1, 8'd6};

    do_reset();

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      in_valid  = vecs[i].iv;
      in_result = vecs[i].res;
      in_op     = vecs[i].op;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk_vec(i, vecs[i]);
    end

    // 256 back-to-back pushes with the consumer always ready: acc_count must wrap to 0.
    do_reset();
    exp_acc = 8'd0;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] d;
      d = 4'(i);
      @(negedge clk);
      in_valid  = 1'b1;
      in_result = d;
      in_op     = d[1:0];
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_acc = exp_acc + 8'd1;
      chk($sformatf("stream%0d.acc", i),   32'(acc_count),  32'(exp_acc));
      chk($sformatf("stream%0d.level", i), 32'(level),      32'd1);
      chk($sformatf("stream%0d.head", i),  32'(out_result), 32'(d));
    end
    chk("wrap.acc_zero", 32'(acc_count), 32'd0);

    // Assert reset while the stream is still running.
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_result = 4'h9;
    @(posedge clk);
    #1;
    chk("midrst.level",      32'(level),      32'd0);
    chk("midrst.out_valid",  32'(out_valid),  32'd0);
    chk("midrst.in_ready",   32'(in_ready),   32'd0);
    chk("midrst.acc",        32'(acc_count),  32'd0);
    chk("midrst.out_result", 32'(out_result), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_rel.in_ready",  32'(in_ready),  32'd1);
    chk("midrst_rel.level",     32'(level),     32'd0);
    chk("midrst_rel.out_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
